cpu_program_loader: RTL and testbench

Parametrised successor of the UART instruction loader. Consumes bytes from uart_rx over a level handshake, decodes a framed load command, assembles little-endian words of WORD_BYTES bytes, writes them into iRAM at a host-supplied base address, verifies an 8-bit checksum, then optionally resets PC and releases the CPU. Sits between uart_rx, iRAM's external write port and the CPU control logic.

---
 rtl/cpu_program_loader.sv | 167 ++++++++++++++++
 tb/tb_cpu_program_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_loader.sv
// Framed UART program loader: takes CMD/ADDR/COUNT/data/CSUM bytes, writes
// little-endian words into iRAM, checks the data-byte checksum, then releases the CPU.
module cpu_program_loader #(
  parameter int WORD_BYTES     = 3,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    HALT_flag,
  input  logic                    packet_ready,
  input  logic [7:0]              uart_packet,
  input  logic                    data_ack,
  input  logic [ADDR_W-1:0]       PC_addr,
  output logic                    packet_ack,
  output logic                    cpu_paused,
  output logic                    reset_PC,
  output logic                    iRAM_write_enable,
  output logic [ADDR_W-1:0]       extern_iRAM_addr,
  output logic [8*WORD_BYTES-1:0] iRAM_data_in,
  output logic                    load_busy,
  output logic                    load_error,
  output logic                    load_done
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA, S_WRITE, S_CSUM, S_PCRST
  } state_t;

  state_t          state, state_next;
  logic [7:0]      cmd, addr_hi, csum;
  logic [8:0]      words_left;
  logic [2:0]      byte_idx;
  logic [DW-1:0]   word_buf, word_next;
  logic [TW-1:0]   timer;
  logic            byte_state, accept, timing, timeout, cmd_valid, last_byte, csum_ok;

  always_comb begin
    byte_state = (state == S_IDLE && HALT_flag) ||
                 (state inside {S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA, S_CSUM});
    accept     = byte_state && packet_ready && !packet_ack;
    timing     = state inside {S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA, S_CSUM};
    timeout    = timing && !accept && (timer == TW'(TIMEOUT_CYCLES - 1));
    cmd_valid  = uart_packet inside {8'h01, 8'h02, 8'h03};
    last_byte  = (byte_idx == 3'(WORD_BYTES - 1));
    csum_ok    = (uart_packet == csum);
    word_next  = word_buf;
    for (int k = 0; k < WORD_BYTES; k++)
      if (byte_idx == 3'(k)) word_next[8*k +: 8] = uart_packet;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept && cmd_valid) state_next = S_ADDR_HI;
      S_ADDR_HI: if (accept) state_next = S_ADDR_LO;
      S_ADDR_LO: if (accept) state_next = S_COUNT;
      S_COUNT:   if (accept) state_next = S_DATA;
      S_DATA:    if (accept && last_byte) state_next = S_WRITE;
      S_WRITE:   if (data_ack) state_next = (words_left == 9'd1) ? S_CSUM : S_DATA;
      S_CSUM:    if (accept) state_next = (csum_ok && cmd == 8'h01) ? S_PCRST : S_IDLE;
      S_PCRST:   if (PC_addr == '0) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Datapath and registered outputs; a timeout overrides whatever the state did.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet_ack        <= 1'b0;
      cpu_paused        <= 1'b0;
      reset_PC          <= 1'b0;
      iRAM_write_enable <= 1'b0;
      extern_iRAM_addr  <= '0;
      iRAM_data_in      <= '0;
      load_busy         <= 1'b0;
      load_error        <= 1'b0;
      load_done         <= 1'b0;
      cmd               <= '0;
      addr_hi           <= '0;
      csum              <= '0;
      words_left        <= '0;
      byte_idx          <= '0;
      word_buf          <= '0;
      timer             <= '0;
    end else begin
      load_done <= 1'b0;
      if (accept)      timer <= '0;
      else if (timing) timer <= timer + TW'(1);
      else             timer <= '0;

      if (accept)            packet_ack <= 1'b1;
      else if (!packet_ready) packet_ack <= 1'b0;

      case (state)
        S_IDLE: if (accept) begin
          if (cmd_valid) begin
            cmd        <= uart_packet;
            load_error <= 1'b0;
            load_busy  <= 1'b1;
            cpu_paused <= 1'b1;
            csum       <= '0;
            byte_idx   <= '0;
          end else begin
            load_error <= 1'b1;
          end
        end
        S_ADDR_HI: if (accept) addr_hi <= uart_packet;
        S_ADDR_LO: if (accept) extern_iRAM_addr <= ADDR_W'({addr_hi, uart_packet});
        S_COUNT:   if (accept) words_left <= (uart_packet == 8'h00) ? 9'd256 : {1'b0, uart_packet};
        S_DATA: if (accept) begin
          csum <= csum + uart_packet;
          if (last_byte) begin
            iRAM_data_in      <= word_next;
            iRAM_write_enable <= 1'b1;
            byte_idx          <= '0;
          end else begin
            word_buf <= word_next;
            byte_idx <= byte_idx + 3'd1;
          end
        end
        S_WRITE: if (data_ack) begin
          iRAM_write_enable <= 1'b0;
          extern_iRAM_addr  <= extern_iRAM_addr + ADDR_W'(1);
          words_left        <= words_left - 9'd1;
        end
        S_CSUM: if (accept) begin
          if (csum_ok) begin
            load_done <= 1'b1;
            case (cmd)
              8'h01:   reset_PC <= 1'b1;
              8'h02:   begin cpu_paused <= 1'b0; load_busy <= 1'b0; end
              default: load_busy <= 1'b0;
            endcase
          end else begin
            load_error <= 1'b1;
            cpu_paused <= 1'b0;
            load_busy  <= 1'b0;
          end
        end
        S_PCRST: if (PC_addr == '0) begin
          reset_PC   <= 1'b0;
          cpu_paused <= 1'b0;
          load_busy  <= 1'b0;
        end
        default: ;
      endcase

      if (timeout) begin
        load_error <= 1'b1;
        cpu_paused <= 1'b0;
        reset_PC   <= 1'b0;
        load_busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: expected iRAM writes are queued by the
// stimulus and popped by a monitor whenever a write request appears.
module tb_cpu_program_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } wr_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        HALT_flag = 1'b1, packet_ready = 1'b0, data_ack = 1'b0;
  logic [7:0]  uart_packet = '0, PC_addr = 8'h37;
  logic        packet_ack, cpu_paused, reset_PC, iRAM_write_enable;
  logic        load_busy, load_error, load_done;
  logic [7:0]  extern_iRAM_addr;
  logic [23:0] iRAM_data_in;

  int  checks = 0, failures = 0;
  int  ack_wait = 0, done_count = 0, we_len = 0, last_we_len = 0, ack_during_write = 0;
  bit  reset_pc_seen = 0;
  wr_t exp_q[$];
  byte_q_t frame;

  cpu_program_loader #(.WORD_BYTES(3), .ADDR_W(8), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .HALT_flag(HALT_flag), .packet_ready(packet_ready),
    .uart_packet(uart_packet), .data_ack(data_ack), .PC_addr(PC_addr),
    .packet_ack(packet_ack), .cpu_paused(cpu_paused), .reset_PC(reset_PC),
    .iRAM_write_enable(iRAM_write_enable), .extern_iRAM_addr(extern_iRAM_addr),
    .iRAM_data_in(iRAM_data_in), .load_busy(load_busy), .load_error(load_error),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    @(negedge clk);
    uart_packet  = b;
    packet_ready = 1'b1;
    n = 0;
    while (!packet_ack && n < 300) begin @(negedge clk); n++; end
    checkOutput("byte_ack_seen", {31'b0, packet_ack}, 32'd1);
    packet_ready = 1'b0;
    n = 0;
    while (packet_ack && n < 300) begin @(negedge clk); n++; end
    checkOutput("byte_ack_drop", {31'b0, packet_ack}, 32'd0);
  endtask

  task automatic sendFrame(input byte_q_t f);
    foreach (f[i]) applyStimulus(f[i]);
  endtask

  // iRAM model: acknowledges each write request after ack_wait extra cycles.
  initial forever begin
    @(negedge clk);
    if (iRAM_write_enable && !data_ack) begin
      repeat (ack_wait) @(negedge clk);
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
    end
  end

  initial begin : monitor
    logic we_prev, ack_prev;
    wr_t  e;
    we_prev = 1'b0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (iRAM_write_enable && !we_prev) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", {24'b0, extern_iRAM_addr}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            checkOutput("write_addr", {24'b0, extern_iRAM_addr}, {24'b0, e.addr});
            checkOutput("write_data", {8'b0, iRAM_data_in}, {8'b0, e.data});
          end
        end
        if (iRAM_write_enable) we_len++;
        else if (we_prev) begin last_we_len = we_len; we_len = 0; end
        if (iRAM_write_enable && we_prev && packet_ack && !ack_prev) ack_during_write++;
        if (load_done) done_count++;
        if (reset_PC) reset_pc_seen = 1'b1;
      end
      we_prev  = iRAM_write_enable;
      ack_prev = packet_ack;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_flags", {25'b0, packet_ack, cpu_paused, reset_PC, iRAM_write_enable,
                load_busy, load_error, load_done}, 32'd0);
    checkOutput("reset_addr", {24'b0, extern_iRAM_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load + reset PC; data checksum 11+22+33+44+55+66 = 0x165 -> 0x65.
    exp_q.push_back('{8'h10, 24'h332211});
    exp_q.push_back('{8'h11, 24'h665544});
    frame = '{8'h01, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
    sendFrame(frame);
    checkOutput("A_reset_PC_held", {31'b0, reset_PC}, 32'd1);
    checkOutput("A_paused_held", {31'b0, cpu_paused}, 32'd1);
    checkOutput("A_busy_held", {31'b0, load_busy}, 32'd1);
    checkOutput("A_done_pulses", done_count, 32'd1);
    PC_addr = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("A_release", {29'b0, reset_PC, cpu_paused, load_busy}, 32'd0);
    checkOutput("A_error", {31'b0, load_error}, 32'd0);

    // Same frame with a wrong checksum.
    PC_addr = 8'h37;
    reset_pc_seen = 1'b0;
    exp_q.push_back('{8'h10, 24'h332211});
    exp_q.push_back('{8'h11, 24'h665544});
    frame[10] = 8'h98;
    sendFrame(frame);
    @(negedge clk);
    checkOutput("B_error", {31'b0, load_error}, 32'd1);
    checkOutput("B_unpaused", {31'b0, cpu_paused}, 32'd0);
    checkOutput("B_no_reset_PC", {31'b0, reset_pc_seen}, 32'd0);
    checkOutput("B_no_done", done_count, 32'd1);

    // Bad command, then a load+run frame at base 0xFF that wraps to 0x00.
    applyStimulus(8'h07);
    checkOutput("C_error", {31'b0, load_error}, 32'd1);
    checkOutput("C_idle", {31'b0, load_busy}, 32'd0);
    applyStimulus(8'h02);
    checkOutput("D_error_cleared", {31'b0, load_error}, 32'd0);
    checkOutput("D_busy_paused", {30'b0, load_busy, cpu_paused}, 32'd3);
    exp_q.push_back('{8'hFF, 24'h030201});
    exp_q.push_back('{8'h00, 24'h060504});
    frame = '{8'h00, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    sendFrame(frame);
    @(negedge clk);
    checkOutput("D_end_flags", {29'b0, cpu_paused, load_busy, load_error}, 32'd0);
    checkOutput("D_done_pulses", done_count, 32'd2);

    // Load+stay paused with a slow iRAM: checksum AA+BB+CC = 0x231 -> 0x31.
    ack_wait = 4;
    exp_q.push_back('{8'h20, 24'hCCBBAA});
    frame = '{8'h03, 8'h00, 8'h20, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    sendFrame(frame);
    @(negedge clk);
    checkOutput("E_we_cycles", last_we_len, 32'd5);
    checkOutput("E_ack_in_write", ack_during_write, 32'd0);
    checkOutput("E_stay_paused", {30'b0, cpu_paused, load_busy}, 32'd2);
    checkOutput("E_done_pulses", done_count, 32'd3);
    ack_wait = 0;

    // Timeout after ADDR_LO.
    frame = '{8'h01, 8'h00, 8'h40};
    sendFrame(frame);
    repeat (40) @(negedge clk);
    checkOutput("F_before_timeout", {30'b0, load_busy, load_error}, 32'd2);
    repeat (20) @(negedge clk);
    checkOutput("F_after_timeout", {29'b0, cpu_paused, load_busy, load_error}, 32'd1);

    // Reset while a write is pending.
    ack_wait = 20;
    exp_q.push_back('{8'h50, 24'h030201});
    frame = '{8'h02, 8'h00, 8'h50, 8'h01, 8'h01, 8'h02, 8'h03};
    sendFrame(frame);
    @(negedge clk);
    checkOutput("G_write_pending", {31'b0, iRAM_write_enable}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("G_rst_flags", {25'b0, packet_ack, cpu_paused, reset_PC, iRAM_write_enable,
                load_busy, load_error, load_done}, 32'd0);
    checkOutput("G_rst_addr_data", {extern_iRAM_addr, iRAM_data_in}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
